pipe_execute_hs: RTL
====================

Name: pipe_execute_hs

Overview:
- Parametrised execute-to-memory pipeline register for the pipelined core, successor to the free-running EX/MEM register.
- Adds a valid/ready handshake, stall back-pressure, a flush, and an optional 2-entry skid buffer.
- The skid buffer lets execute see a registered ready.
- Sits between the ALU stage and the data-memory stage, carrying both the datapath and the control bundle.

Parameters:
- DATA_WIDTH, 32, width of aluresult, writedata, pcplus4.
- WRITE_WIDTH, 5, width of destination register index rd.
- RESULTSRC_WIDTH, 2, width of resultsrc select.
- SKID_EN, 1, 1 = 2-entry skid buffer with registered ready_e; 0 = single register with combinational ready_e.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- valid_e  in  1  execute stage presents a valid instruction.
- ready_e  out  1  this block can accept from execute this cycle.
- flush  in  1  kill all held instructions (branch mispredict/trap).
- aluresulte  in  DATA_WIDTH  ALU result.
- writedatae  in  DATA_WIDTH  store data.
- rde  in  WRITE_WIDTH  destination register.
- pcplus4e  in  DATA_WIDTH  PC+4.
- regwritee  in  1  register write enable.
- resultsrce  in  RESULTSRC_WIDTH  writeback select.
- memwritee  in  1  memory write enable.
- valid_m  out  1  memory stage output holds a valid instruction.
- ready_m  in  1  memory stage accepts this cycle.
- aluresultm, writedatam, pcplus4m  out  DATA_WIDTH  registered datapath.
- rdm  out  WRITE_WIDTH  registered destination.
- regwritem  out  1  registered control, gated by valid.
- resultsrcm  out  RESULTSRC_WIDTH  registered control.
- memwritem  out  1  registered control, gated by valid.

Behaviour:
- Handshakes:
  - in_fire = valid_e & ready_e.
  - out_fire = valid_m & ready_m.
  - valid_e may drop without waiting for ready_e.
  - Payload must stay stable while valid_m=1 and ready_m=0.
- Reset (async, immediate on rst high):
  - valid_m=0 and skid valid=0.
  - All data/control outputs are 0.
  - ready_e=1 during and after reset.
- Outputs are driven only from the main register. regwritem and memwritem are 0 whenever valid_m=0, so bubbles never write.
- SKID_EN=1, three states:
  - EMPTY:
    - in_fire -> ONE, main <= input.
  - ONE:
    - in_fire & out_fire -> ONE, main <= input.
    - in_fire & !out_fire -> FULL, skid <= input.
    - !in_fire & out_fire -> EMPTY.
    - Otherwise hold.
  - FULL:
    - ready_e=0.
    - out_fire -> ONE, main <= skid.
    - Otherwise hold.
  - ready_e = !skid_valid, driven straight from a flop.
- SKID_EN=0:
  - ready_e = !valid_m | ready_m (combinational).
  - in_fire loads main, valid_m<=1.
  - out_fire without in_fire sets valid_m<=0.
  - Otherwise hold.
- Latency: 1 cycle from in_fire to valid_m when the block is empty. Throughput is 1 per cycle when ready_m stays high.
- Flush:
  - Synchronous; has priority over every other event.
  - On the next edge: valid_m=0, skid_valid=0, regwritem=0, memwritem=0, state EMPTY.
  - An in_fire in the same cycle is discarded.
  - Data fields may keep stale values.
  - ready_e=1 the cycle after a flush.
- Simultaneous flush & out_fire: the consumed instruction counts as delivered; nothing new is loaded.
- No reordering: instructions leave in arrival order. The skid entry never bypasses main.
- Reset asserted mid-transfer: all held instructions are dropped; no partial state remains.

Test Plan:
- Reset, then drive valid_e=1 with aluresulte=0x00000010, rde=5, regwritee=1, ready_m=1 -> next cycle valid_m=1, aluresultm=0x10, rdm=5, regwritem=1; one cycle later with valid_e=0 -> valid_m=0, regwritem=0.
- Back-to-back stream of 8 instructions, aluresulte=1..8, ready_m=1 -> valid_m high for 8 consecutive cycles; outputs 1..8 in order; ready_e never drops.
- SKID_EN=1: hold ready_m=0, send A=0xA, B=0xB -> main=A and skid=B, ready_e=0 on the next cycle, C held off; release ready_m -> A, B, C delivered in order with no loss or duplication.
- FULL state plus flush=1 -> next cycle valid_m=0, memwritem=0, regwritem=0, ready_e=1; a subsequent D=0xD arrives alone at the output.
- SKID_EN=0 with ready_m toggling 1,0,1,0 and valid_e=1 continuously -> ready_e equals !valid_m|ready_m each cycle; payload stable while stalled.
- Assert rst mid-stream (async, between edges) -> all outputs zero immediately, valid_m=0; after deassert the first in_fire appears at the output 1 cycle later.

Source files
------------

// File: rtl/pipe_execute_hs.sv
// pipe_execute_hs
//
// Execute-to-memory pipeline register with a valid/ready handshake on both
// sides, a synchronous flush and an optional 2-entry skid buffer.
//
// Parameters:
//   DATA_WIDTH      width of aluresult / writedata / pcplus4
//   WRITE_WIDTH     width of the destination register index
//   RESULTSRC_WIDTH width of the writeback select
//   SKID_EN         1: 2-entry skid buffer, ready_e comes from a flop
//                   0: single register, ready_e is combinational
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   valid_e / ready_e          handshake with the execute stage
//   flush                      drop every held instruction on the next edge
//   aluresulte..memwritee      instruction payload from execute
//   valid_m / ready_m          handshake with the memory stage
//   aluresultm..memwritem      registered payload towards memory; the write
//                              enables are forced low while valid_m is low
module pipe_execute_hs #(
  parameter int DATA_WIDTH      = 32,
  parameter int WRITE_WIDTH     = 5,
  parameter int RESULTSRC_WIDTH = 2,
  parameter int SKID_EN         = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_e,
  output logic                       ready_e,
  input  logic                       flush,
  input  logic [DATA_WIDTH-1:0]      aluresulte,
  input  logic [DATA_WIDTH-1:0]      writedatae,
  input  logic [WRITE_WIDTH-1:0]     rde,
  input  logic [DATA_WIDTH-1:0]      pcplus4e,
  input  logic                       regwritee,
  input  logic [RESULTSRC_WIDTH-1:0] resultsrce,
  input  logic                       memwritee,
  output logic                       valid_m,
  input  logic                       ready_m,
  output logic [DATA_WIDTH-1:0]      aluresultm,
  output logic [DATA_WIDTH-1:0]      writedatam,
  output logic [DATA_WIDTH-1:0]      pcplus4m,
  output logic [WRITE_WIDTH-1:0]     rdm,
  output logic                       regwritem,
  output logic [RESULTSRC_WIDTH-1:0] resultsrcm,
  output logic                       memwritem
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]      aluresult;
    logic [DATA_WIDTH-1:0]      writedata;
    logic [WRITE_WIDTH-1:0]     rd;
    logic [DATA_WIDTH-1:0]      pcplus4;
    logic                       regwrite;
    logic [RESULTSRC_WIDTH-1:0] resultsrc;
    logic                       memwrite;
  } payload_t;

  // EMPTY: nothing held, ONE: main holds an instruction, FULL: main and skid
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t   state, state_next;
  payload_t main_q, skid_q, in_pay;
  logic     in_fire, out_fire;
  logic     load_main_in, load_main_skid, load_skid;

  assign in_pay = '{aluresult: aluresulte, writedata: writedatae, rd: rde,
                    pcplus4: pcplus4e, regwrite: regwritee,
                    resultsrc: resultsrce, memwrite: memwritee};

  assign valid_m  = (state != EMPTY);
  assign in_fire  = valid_e & ready_e;
  assign out_fire = valid_m & ready_m;

  generate
    if (SKID_EN != 0) begin : g_skid
      logic ready_q;
      // ready_e is precomputed from the next state so execute sees a flop
      always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_q <= 1'b1;
        else     ready_q <= (state_next != FULL);
      end
      assign ready_e = ready_q;
    end else begin : g_comb
      assign ready_e = ~valid_m | ready_m;
    end
  endgenerate

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_next   = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            // Only reachable with the skid buffer: without it ready_e
            // requires ready_m whenever main is occupied.
            state_next = FULL;
            load_skid  = 1'b1;
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_next     = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // Data fields are left stale on flush/drain; valid gating hides them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_pay;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_pay;
    end
  end

  assign aluresultm = main_q.aluresult;
  assign writedatam = main_q.writedata;
  assign pcplus4m   = main_q.pcplus4;
  assign rdm        = main_q.rd;
  assign resultsrcm = main_q.resultsrc;
  assign regwritem  = main_q.regwrite & valid_m;
  assign memwritem  = main_q.memwrite & valid_m;

endmodule
